// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC dot-product datapath.
package mac_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } mac_seq_state_t;

endpackage

// File: rtl/mac_unit.sv
// Combinational unsigned multiply-accumulate: c = a*w + b, truncated to ACC_W bits.
module mac_unit
    import mac_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] w,
    input  logic [ACC_W-1:0]  b,
    output logic [ACC_W-1:0]  c
);

    logic [ACC_W-1:0] prod;

    assign prod = ACC_W'(a) * ACC_W'(w);
    assign c    = prod + b;

endmodule

// File: rtl/mac_dot_seq.sv
// Sequencer streaming operand pairs through one mac_unit to form bias + sum(a*w),
// presenting the 16-bit result and a sticky wrap flag on a valid/ready port.
module mac_dot_seq
    import mac_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ACC_W-1:0]  bias,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf
);

    mac_seq_state_t   state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] mac_c;

    mac_unit u_mac (
        .a (in_a),
        .w (in_w),
        .b (acc_q),
        .c (mac_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = bias;
                    cnt_d   = len;
                    ovf_d   = 1'b0;
                    state_d = (len != '0) ? ACC : DONE;
                end
            end
            ACC: begin
                // in_ready is implied in ACC, so in_valid alone marks a handshake
                if (in_valid) begin
                    acc_d = mac_c;
                    ovf_d = ovf_q | (mac_c < acc_q);
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Randomized and directed bench for mac_dot_seq against a plain-arithmetic dot-product model.
module tb_mac_dot_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic [15:0] bias;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_w;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;

    always #5 clk = ~clk;

    mac_dot_seq #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        logic [15:0] d;
        logic        o;
        int          n;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         checks   = 0;
    int         failures = 0;
    int         hs_cnt   = 0;
    logic [7:0] ja[256];
    logic [7:0] jw[256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: bias plus the running sum of products, wrapping at 2^16.
    task automatic model(input int n, input logic [15:0] b,
                         output logic [15:0] d, output logic o);
        int unsigned s;
        s = 32'(b);
        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = s + 32'(ja[i]) * 32'(jw[i]);
            if (s > 32'hFFFF) begin
                o = 1'b1;
                s = s & 32'hFFFF;
            end
        end
        d = s[15:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hs_cnt = 0;
        end else begin
            if (in_valid && in_ready) hs_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_ovf", 32'(out_ovf), 32'(e.o));
                    chk("handshakes", hs_cnt, e.n);
                end
                hs_cnt = 0;
            end
        end
    end

    task automatic run_job(input int n, input logic [15:0] b, input int gap,
                           input bit rnd_gap, input int hold);
        logic [15:0] md;
        logic        mo;
        int          to;
        int          g;
        bit          r;
        model(n, b, md, mo);
        exp_q.push_back('{d: md, o: mo, n: n});
        tick();
        start = 1'b1;
        len   = 8'(n);
        bias  = b;
        tick();
        start = 1'b0;
        len   = 8'($urandom);
        bias  = 16'($urandom);
        if (n == 0) begin
            #3;
            chk("len0_out_valid", 32'(out_valid), 32'd1);
            chk("len0_in_ready", 32'(in_ready), 32'd0);
        end
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_a     = ja[i];
            in_w     = jw[i];
            to       = 0;
            do begin
                #3;
                r = in_ready;
                tick();
                to++;
            end while (!r && to < 100);
            if (!r) begin
                $display("FAIL hs_timeout actual=no_in_ready required=in_ready at %0t", $time);
                $fatal(1, "handshake timeout");
            end
            in_valid = 1'b0;
            in_a     = 8'($urandom);
            in_w     = 8'($urandom);
            if (i == n - 1) begin
                #3;
                chk("lat_out_valid", 32'(out_valid), 32'd1);
            end else begin
                g = rnd_gap ? int'($urandom_range(gap, 0)) : gap;
                repeat (g) tick();
            end
        end
        for (int k = 0; k < hold; k++) begin
            start = 1'($urandom);
            len   = 8'd0;
            bias  = 16'($urandom);
            tick();
            #3;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_out_data", 32'(out_data), 32'(md));
            chk("hold_out_ovf", 32'(out_ovf), 32'(mo));
        end
        start     = 1'b1;
        len       = 8'd0;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        #3;
        chk("back_idle_busy", 32'(busy), 32'd0);
        chk("back_idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] md;
        logic        mo;
        int          n;
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        bias      = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_w      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        rst_n = 1'b1;

        ja[0] = 8'd2; jw[0] = 8'd3;
        ja[1] = 8'd4; jw[1] = 8'd5;
        ja[2] = 8'd1; jw[2] = 8'd1;
        model(3, 16'd10, md, mo);
        chk("model_basic", 32'({mo, md}), 32'({1'b0, 16'd37}));
        run_job(3, 16'd10, 0, 1'b0, 0);

        model(0, 16'h1234, md, mo);
        chk("model_empty", 32'({mo, md}), 32'({1'b0, 16'h1234}));
        run_job(0, 16'h1234, 0, 1'b0, 2);

        ja[0] = 8'd255; jw[0] = 8'd255;
        ja[1] = 8'd1;   jw[1] = 8'd1;
        model(2, 16'hFF00, md, mo);
        chk("model_ovf", 32'({mo, md}), 32'({1'b1, 16'hFD02}));
        run_job(2, 16'hFF00, 0, 1'b0, 0);

        ja[0] = 8'($urandom); jw[0] = 8'($urandom);
        ja[1] = 8'($urandom); jw[1] = 8'($urandom);
        run_job(2, 16'($urandom), 3, 1'b0, 5);

        // Reset part-way through a 4-pair job
        tick();
        start = 1'b1;
        len   = 8'd4;
        bias  = 16'd0;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_a     = 8'd5;
        in_w     = 8'd6;
        tick();
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_data", 32'(out_data), 32'd0);
        chk("async_rst_out_ovf", 32'(out_ovf), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        ja[0] = 8'd3; jw[0] = 8'd3;
        model(1, 16'd0, md, mo);
        chk("model_after_rst", 32'({mo, md}), 32'({1'b0, 16'd9}));
        run_job(1, 16'd0, 0, 1'b0, 0);

        for (int i = 0; i < 255; i++) begin
            ja[i] = 8'd1;
            jw[i] = 8'd1;
        end
        model(255, 16'd0, md, mo);
        chk("model_maxlen", 32'({mo, md}), 32'({1'b0, 16'd255}));
        run_job(255, 16'd0, 0, 1'b0, 1);

        for (int j = 0; j < 25; j++) begin
            n = int'($urandom_range(20, 0));
            for (int i = 0; i < n; i++) begin
                ja[i] = 8'($urandom);
                jw[i] = 8'($urandom);
            end
            run_job(n, 16'($urandom), 2, 1'b1, int'($urandom_range(3, 0)));
        end

        tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
